// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter
// Owns the single-port frame-buffer RAM pins and shares them between the video
// read path (fixed latency, never stalled), a full-screen clear engine and the
// tracer write port. One RAM access per cycle, chosen combinationally and
// registered onto ram_*/grant for the following cycle.
`timescale 1ns/1ps
module frame_buffer_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  vid_rd_en,
   input  logic [ADDR_WIDTH-1:0] vid_addr,
   output logic [DATA_WIDTH-1:0] vid_rd_data,
   output logic                  vid_rd_valid,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ack,
   input  logic                  clr_start,
   input  logic [DATA_WIDTH-1:0] clr_color,
   output logic                  clr_busy,
   output logic                  clr_done,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_DONE  = 2'd2
   } clr_state_t;

   typedef enum logic [1:0] {
      GNT_IDLE = 2'd0,
      GNT_VID  = 2'd1,
      GNT_CLR  = 2'd2,
      GNT_WR   = 2'd3
   } grant_t;

   clr_state_t            state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] color, color_nxt;

   grant_t                owner;
   grant_t                grant_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] din_q;
   logic [1:0]            vid_pipe;

   // Busy/done decode straight from the state register so reset clears them at once.
   assign clr_busy = (state == S_CLEAR);
   assign clr_done = (state == S_DONE);

   // Fixed-priority arbitration: video > clear sweep > tracer write.
   // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
   always_comb begin
      owner  = GNT_IDLE;
      wr_ack = 1'b0;
      if (vid_rd_en) begin
         owner = GNT_VID;
      end else if (clr_busy) begin
         owner = GNT_CLR;
      end else if (wr_req && !reset) begin
         owner  = GNT_WR;
         wr_ack = 1'b1;
      end
   end

   // Clear engine next state: sweeps every address once, pausing on video cycles.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      color_nxt = color;
      case (state)
         S_IDLE: begin
            if (clr_start) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
               color_nxt = clr_color;
            end
         end
         S_CLEAR: begin
            if (!vid_rd_en) begin
               // Terminal detect on all-ones so the counter never wraps into a second write of 0.
               if (&cnt) state_nxt = S_DONE;
               else      cnt_nxt   = cnt + ADDR_WIDTH'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Clear engine state register.
   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         color <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         color <= color_nxt;
      end
   end

   // Register the winning request onto the RAM pins; no winner holds address and data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         grant_q <= GNT_IDLE;
      end else begin
         grant_q <= owner;
         case (owner)
            GNT_VID: begin
               we_q   <= 1'b0;
               addr_q <= vid_addr;
            end
            GNT_CLR: begin
               we_q   <= 1'b1;
               addr_q <= cnt;
               din_q  <= color;
            end
            GNT_WR: begin
               we_q   <= 1'b1;
               addr_q <= wr_addr;
               din_q  <= wr_data;
            end
            default: we_q <= 1'b0;
         endcase
      end
   end

   // Read-valid pipeline: address on the pins in N+1, RAM output valid in N+2.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) vid_pipe <= 2'b00;
      else       vid_pipe <= {vid_pipe[0], vid_rd_en};
   end

   assign vid_rd_valid = vid_pipe[1];
   assign vid_rd_data  = ram_dout;
   assign ram_we       = we_q;
   assign ram_addr     = addr_q;
   assign ram_din      = din_q;
   assign grant        = grant_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter
// Cycle model of the arbiter drives a scoreboard: each driven cycle pushes the
// expected RAM-pin state for the next cycle and any expected read pixel; a
// monitor pops and compares one cycle later. A small RAM model closes the loop.
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;

   localparam int AW = 4;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          vid_rd_en;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_rd_data;
   logic          vid_rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          clr_start;
   logic [DW-1:0] clr_color;
   logic          clr_busy;
   logic          clr_done;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic [1:0]    grant;

   always #5 clk = ~clk;

   frame_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .vid_rd_en(vid_rd_en), .vid_addr(vid_addr),
      .vid_rd_data(vid_rd_data), .vid_rd_valid(vid_rd_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .clr_start(clr_start), .clr_color(clr_color),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .grant(grant)
   );

   // Single-port RAM: registered address, asynchronous read from it.
   logic [DW-1:0] mem [16] = '{default: '0};
   logic [AW-1:0] mem_addr_q = '0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      mem_addr_q <= ram_addr;
   end
   assign ram_dout = mem[mem_addr_q];

   typedef struct {
      logic [1:0]    g;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
      logic          busy;
      logic          done;
      logic          valid;
   } exp_t;

   exp_t          exp_q [$];
   logic [DW-1:0] rd_q [$];
   exp_t          mon_e;

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt = 0;
   int done_cnt = 0;

   // Reference model state
   logic [DW-1:0] ref_mem [16] = '{default: '0};
   int            m_state;   // 0 idle, 1 clearing, 2 done
   logic [AW-1:0] m_cnt, m_addr, m_pend_addr;
   logic [DW-1:0] m_color, m_din, m_pend_data;
   logic          m_v1, m_ack, m_pend;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Monitor: compare registered outputs against the oldest expectation.
   always begin
      @(posedge clk);
      #1;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("grant",        32'(grant),        32'(mon_e.g));
         check("ram_we",       32'(ram_we),       32'(mon_e.we));
         check("ram_addr",     32'(ram_addr),     32'(mon_e.addr));
         check("ram_din",      32'(ram_din),      32'(mon_e.din));
         check("clr_busy",     32'(clr_busy),     32'(mon_e.busy));
         check("clr_done",     32'(clr_done),     32'(mon_e.done));
         check("vid_rd_valid", 32'(vid_rd_valid), 32'(mon_e.valid));
         if (mon_e.valid && rd_q.size() > 0)
            check("vid_rd_data", 32'(vid_rd_data), 32'(rd_q.pop_front()));
      end
   end

   // Drive one cycle of stimulus and advance the model by one cycle.
   task automatic cycle(input logic v, input logic [AW-1:0] va,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic cs, input logic [DW-1:0] cc);
      exp_t e;
      logic busy;
      @(posedge clk);
      #3;
      vid_rd_en = v;  vid_addr = va;
      wr_req = wr;    wr_addr = wa;  wr_data = wd;
      clr_start = cs; clr_color = cc;
      #1;
      // Write issued last cycle lands in RAM at the end of this one.
      if (m_pend) ref_mem[m_pend_addr] = m_pend_data;
      m_pend = 1'b0;
      busy  = (m_state == 1);
      m_ack = wr && !v && !busy;
      check("wr_ack", 32'(wr_ack), 32'(m_ack));
      e.g = 2'd0; e.we = 1'b0;
      if (v) begin
         e.g = 2'd1; m_addr = va;
         rd_q.push_back(ref_mem[va]);
      end else if (busy) begin
         e.g = 2'd2; e.we = 1'b1; m_addr = m_cnt; m_din = m_color;
      end else if (wr) begin
         e.g = 2'd3; e.we = 1'b1; m_addr = wa; m_din = wd;
      end
      if (e.we) begin
         m_pend = 1'b1; m_pend_addr = m_addr; m_pend_data = m_din;
      end
      e.addr = m_addr;
      e.din  = m_din;
      case (m_state)
         0: if (cs) begin m_state = 1; m_cnt = '0; m_color = cc; end
         1: if (!v) begin
               if (m_cnt == 4'hF) m_state = 2;
               else               m_cnt = m_cnt + 4'd1;
            end
         default: m_state = 0;
      endcase
      e.busy  = (m_state == 1);
      e.done  = (m_state == 2);
      e.valid = m_v1;
      m_v1    = v;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   // Reset between cycles; checks outputs while reset is held.
   task automatic apply_reset(input logic wr_hold);
      @(posedge clk);
      #2;
      vid_rd_en = 1'b0; vid_addr = '0; wr_addr = '0; wr_data = '0;
      clr_start = 1'b0; clr_color = '0;
      wr_req = wr_hold;
      reset  = 1'b1;
      #1;
      check("rst_ram_we",   32'(ram_we),       32'd0);
      check("rst_ram_addr", 32'(ram_addr),     32'd0);
      check("rst_ram_din",  32'(ram_din),      32'd0);
      check("rst_grant",    32'(grant),        32'd0);
      check("rst_valid",    32'(vid_rd_valid), 32'd0);
      check("rst_wr_ack",   32'(wr_ack),       32'd0);
      check("rst_busy",     32'(clr_busy),     32'd0);
      check("rst_done",     32'(clr_done),     32'd0);
      exp_q.delete();
      rd_q.delete();
      m_state = 0; m_cnt = '0; m_addr = '0; m_din = '0; m_color = '0;
      m_v1 = 1'b0; m_pend = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset  = 1'b0;
      wr_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ack_seen;
      reset = 1'b1;
      vid_rd_en = 1'b0; vid_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      clr_start = 1'b0; clr_color = '0;

      // 1: reset, then idle with no RAM activity
      apply_reset(1'b0);
      idle(20);

      // 2: single tracer write, then read it back
      cycle(1'b0, '0, 1'b1, 4'h3, 3'd5, 1'b0, '0);
      cycle(1'b1, 4'h3, 1'b0, '0, '0, 1'b0, '0);
      idle(4);

      // 3: video every cycle blocks a held write; first free cycle acks it
      for (int i = 0; i < 10; i++) cycle(1'b1, AW'(i), 1'b1, 4'hC, 3'd4, 1'b0, '0);
      cycle(1'b0, '0, 1'b1, 4'hC, 3'd4, 1'b0, '0);
      cycle(1'b1, 4'hC, 1'b0, '0, '0, 1'b0, '0);
      idle(4);

      // 4: clear sweep with video on every third cycle, then read all
      busy_cnt = 0; done_cnt = 0;
      cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 3'd2);
      for (int k = 0; k < 100 && m_state == 1; k++)
         cycle((k % 3) == 0, AW'(k / 3), 1'b0, '0, '0, 1'b0, '0);
      idle(3);
      check("sweep_busy_cycles", 32'(busy_cnt), 32'd24);
      check("sweep_done_pulses", 32'(done_cnt), 32'd1);
      for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, '0);
      idle(3);

      // 5: write with clr_start acked at once; held write during clear waits; restart ignored
      done_cnt = 0;
      cycle(1'b0, '0, 1'b1, 4'h9, 3'd7, 1'b1, 3'd6);
      ack_seen = 1'b0;
      for (int k = 0; k < 60 && !ack_seen; k++) begin
         cycle(1'b0, '0, 1'b1, 4'hA, 3'd7, k == 5, 3'd1);
         ack_seen = m_ack;
      end
      idle(3);
      check("clr5_done_pulses", 32'(done_cnt), 32'd1);
      for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, '0);
      idle(3);

      // 6: reset in the middle of a sweep
      cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 3'd3);
      for (int k = 0; k < 40 && !(m_state == 1 && m_cnt == 4'd7); k++) idle(1);
      done_cnt = 0;
      apply_reset(1'b1);
      idle(12);
      check("abort_done_pulses", 32'(done_cnt), 32'd0);
      check("abort_busy", 32'(clr_busy), 32'd0);
      for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, '0);
      idle(4);

      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
